// File: rtl/gecko_pkg.sv
// Shared types for the gecko core: register-sized values and the fetch queue entry.
// The fetch entry pairs each fetched instruction word with the PC it was fetched from.
package gecko;

    typedef logic [31:0] rv32_reg_value_t;

    typedef struct packed {
        rv32_reg_value_t pc;
        rv32_reg_value_t instruction;
    } gecko_fetch_entry_t;

    localparam rv32_reg_value_t GECKO_INSTR_BYTES = 32'd4;

    function automatic rv32_reg_value_t gecko_word_align(input rv32_reg_value_t addr);
        return addr & ~rv32_reg_value_t'(3);
    endfunction

endpackage

// File: rtl/gecko_fetch_queue.sv
// In-order fetch buffer between the memory response port and decode.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module gecko_fetch_queue
    import gecko::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  gecko_fetch_entry_t         push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output gecko_fetch_entry_t         head_o,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    gecko_fetch_entry_t entries_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) entries_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

    assign occupancy_o = wr_ptr_q - rd_ptr_q;
    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (occupancy_o == (AW+1)'(DEPTH));
    assign head_o      = entries_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/gecko_fetch.sv
// gecko fetch stage: sequential PC requests, credit-limited, responses queued for decode.
// Optional GECKO_FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module gecko_fetch
    import gecko::*;
#(
    parameter rv32_reg_value_t START_ADDR  = 32'h0000_0000,
    parameter int unsigned     QUEUE_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output rv32_reg_value_t mem_req_addr,
    input  logic            mem_resp_valid,
    input  rv32_reg_value_t mem_resp_data,
    input  logic            jump_valid,
    input  rv32_reg_value_t jump_addr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output rv32_reg_value_t instr_pc,
    output rv32_reg_value_t instr_data
);

    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

    rv32_reg_value_t    req_pc_q, req_pc_d;
    rv32_reg_value_t    resp_pc_q, resp_pc_d;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]      discard_q, discard_d;
    logic [CW-1:0]      occupancy;
    logic [CW:0]        credit_used;
    gecko_fetch_entry_t head;
    gecko_fetch_entry_t push_entry;
    logic               queue_empty, queue_full;
    logic               issue, resp_keep, bypass, push, pop;

    // Queued entries and outstanding requests share one credit pool, so a push never overflows.
    assign credit_used   = {1'b0, inflight_q} + {1'b0, occupancy};
    assign mem_req_valid = rst && !jump_valid && (credit_used < (CW+1)'(QUEUE_DEPTH));
    assign mem_req_addr  = req_pc_q;
    assign issue         = mem_req_valid && mem_req_ready;

    assign resp_keep = mem_resp_valid && !jump_valid && (discard_q == '0);
`ifdef GECKO_FETCH_BYPASS_EN
    assign bypass = resp_keep && queue_empty && instr_ready;
`else
    assign bypass = 1'b0;
`endif
    assign push        = resp_keep && !bypass;
    assign instr_valid = rst && !jump_valid && (!queue_empty || bypass);
    assign pop         = instr_valid && instr_ready && !bypass;
    assign push_entry  = '{pc: resp_pc_q, instruction: mem_resp_data};

    always_comb begin
        instr_pc   = '0;
        instr_data = '0;
        if (bypass) begin
            instr_pc   = resp_pc_q;
            instr_data = mem_resp_data;
        end else if (instr_valid) begin
            instr_pc   = head.pc;
            instr_data = head.instruction;
        end
    end

    // A redirect restarts both PCs and marks every still-outstanding old-path response for dropping.
    always_comb begin
        req_pc_d   = req_pc_q;
        resp_pc_d  = resp_pc_q;
        discard_d  = discard_q;
        inflight_d = inflight_q + CW'(issue) - CW'(mem_resp_valid);
        if (jump_valid) begin
            req_pc_d  = gecko_word_align(jump_addr);
            resp_pc_d = gecko_word_align(jump_addr);
            discard_d = inflight_q - CW'(mem_resp_valid);
        end else begin
            if (issue) req_pc_d = req_pc_q + GECKO_INSTR_BYTES;
            if (mem_resp_valid) begin
                if (discard_q != '0) discard_d = discard_q - CW'(1);
                else                 resp_pc_d = resp_pc_q + GECKO_INSTR_BYTES;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_pc_q   <= START_ADDR;
            resp_pc_q  <= START_ADDR;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            req_pc_q   <= req_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    gecko_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk_i       (clk),
        .rst_ni      (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (jump_valid),
        .head_o      (head),
        .occupancy_o (occupancy),
        .empty_o     (queue_empty),
        .full_o      (queue_full)
    );

    a_resp_without_request: assert property (@(posedge clk) disable iff (!rst)
        !(mem_resp_valid && inflight_q == '0));
    a_push_into_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && queue_full && !pop));

endmodule
